incident_edge_search: RTL and testbench
=======================================

Name: incident_edge_search

Overview:
- Parametrised successor to the incident-edge finder in the collision narrow phase.
- Scans NUM_EDGES polygon face normals and selects the one whose dot product with the reference-face normal is most negative. That normal is the incident face.
- Sits between the reference-face selection and the clipping stage.
- Adds relative to the previous block:
  - generic normal width and edge count;
  - a correct first-candidate initialisation, so a result is produced even when all products are positive;
  - a busy/done handshake with restart;
  - a registered minimum-dot output.

Parameters:
- WIDTH, 10, signed bit width of each normal component.
- NUM_EDGES, 4, number of candidate normals; legal range 2..16.
- IDX_W, 2, index width; must equal clog2(NUM_EDGES), minimum 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  single-cycle request; samples all data inputs.
- referenceNorm_x  in  WIDTH  signed reference normal x.
- referenceNorm_y  in  WIDTH  signed reference normal y.
- norms_x  in  NUM_EDGES*WIDTH  packed signed x components; edge i occupies bits [i*WIDTH +: WIDTH].
- norms_y  in  NUM_EDGES*WIDTH  packed signed y components; same layout as norms_x.
- busy  out  1  high while scanning.
- done_out  out  1  one-cycle pulse when the result is valid.
- incidentIndex  out  IDX_W  index of the selected normal.
- incidentNorm_x  out  WIDTH  x component of the selected normal, from latched copies.
- incidentNorm_y  out  WIDTH  y component of the selected normal, from latched copies.
- minDot  out  2*WIDTH+1  signed dot product of the selected normal with the reference.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE;
  - busy, done_out, incidentIndex, minDot = 0;
  - latched normals and reference = 0, so incidentNorm_x/y = 0;
  - reset overrides start and aborts any scan in progress.
- States:
  - IDLE: start=1 latches the reference and all normals, sets cnt=0, goes to SCAN, busy=1.
  - SCAN: each cycle evaluates edge cnt, then increments cnt. After cnt=NUM_EDGES-1 is evaluated, goes to DONE, busy=0, done_out=1.
  - DONE: held one cycle only; done_out returns to 0 and the state goes to IDLE.
- Results hold stable from the done_out cycle until the next start is accepted.
- Latency: start sampled at edge E0 gives done_out high in the cycle after edge E(NUM_EDGES).
- Throughput: one search per NUM_EDGES+1 cycles.
- Dot product:
  - dot = nx*rx + ny*ry, computed from the latched copies, never the live inputs;
  - sign-extended to 2*WIDTH+1 bits before the add; no overflow is possible.
- Selection:
  - edge 0 unconditionally initialises minDot and incidentIndex=0; there is no comparison against zero;
  - edge k>0 replaces the current choice only if dot < minDot (strict);
  - ties therefore keep the lowest index.
- start asserted while in SCAN: the scan aborts, new inputs are re-latched, cnt=0, busy stays 1, and no done_out is produced for the aborted scan.
- start asserted in the DONE cycle: done_out still pulses that cycle, and the new scan is accepted.
- Live input changes after the start cycle have no effect on the result.
- incidentNorm_x/y are a combinational mux of the latched normals by incidentIndex.

Optional Feature:
- Macro: INCIDENT_DUAL_LANE_EN.
- When defined:
  - two edges are evaluated per SCAN cycle (cnt and cnt+1);
  - cnt steps by 2 and latency becomes ceil(NUM_EDGES/2) cycles from start to done_out;
  - for odd NUM_EDGES, the last cycle evaluates one edge only;
  - within a lane pair the lower index wins ties, and overall results are bit-identical to the single-lane mode.
- When undefined: single multiplier pair, one edge per cycle, as specified above.

Test Plan:
- Box normals (0,256),(256,0),(0,-256),(-256,0), ref (0,256): done_out 4 cycles after start; incidentIndex=2, incidentNorm=(0,-256), minDot=-65536, busy low on done.
- All-positive products, ref (256,0), normals (256,0),(200,10),(100,0),(255,0): incidentIndex=2, minDot=25600; this checks the no-zero-init rule.
- Tie, ref (256,256), normals (-256,0),(0,-256),(256,0),(0,256): both candidates give -65536; incidentIndex=0.
- Restart: start, then start again 2 cycles later with shifted inputs. Exactly one done_out, 4 cycles after the second start, with the result for the second input set; input changes after each start are ignored.
- Reset mid-scan: rst_n=0 while cnt=2, then start. All outputs are 0 after reset, no spurious done_out, and the next search is correct.
- NUM_EDGES=5, WIDTH=12, extreme values, ref (-2048,-2048), normal 4 = (-2048,-2048), others 0: minDot=+8388608 is not selected; incidentIndex=0, minDot=0. Repeat with INCIDENT_DUAL_LANE_EN defined: identical results, done_out after 3 cycles.

Source files
------------

// File: rtl/incident_edge_search_if.sv
// Request/result bundle for the incident-edge search.
// master drives the request, slave returns the selected edge.
interface incident_edge_search_if #(
  parameter int WIDTH     = 10,
  parameter int NUM_EDGES = 4,
  parameter int IDX_W     = 2
);
  logic                       start;
  logic signed [WIDTH-1:0]    referenceNorm_x;
  logic signed [WIDTH-1:0]    referenceNorm_y;
  logic [NUM_EDGES*WIDTH-1:0] norms_x;
  logic [NUM_EDGES*WIDTH-1:0] norms_y;
  logic                       busy;
  logic                       done_out;
  logic [IDX_W-1:0]           incidentIndex;
  logic signed [WIDTH-1:0]    incidentNorm_x;
  logic signed [WIDTH-1:0]    incidentNorm_y;
  logic signed [2*WIDTH:0]    minDot;

  modport master (
    output start, referenceNorm_x, referenceNorm_y,
    output norms_x, norms_y,
    input  busy, done_out, incidentIndex,
    input  incidentNorm_x, incidentNorm_y, minDot
  );

  modport slave (
    input  start, referenceNorm_x, referenceNorm_y,
    input  norms_x, norms_y,
    output busy, done_out, incidentIndex,
    output incidentNorm_x, incidentNorm_y, minDot
  );
endinterface

// File: rtl/incident_edge_search.sv
// Incident-edge search: picks the face normal with the most negative
// dot product against the reference normal. INCIDENT_DUAL_LANE_EN: 2 edges/cycle.
module incident_edge_search #(
  parameter int WIDTH     = 10,
  parameter int NUM_EDGES = 4,
  parameter int IDX_W     = 2
) (
  input logic                    clk,
  input logic                    rst_n,
  incident_edge_search_if.slave  bus
);
  localparam int DW = 2*WIDTH+1;
  localparam int CW = IDX_W+1;
`ifdef INCIDENT_DUAL_LANE_EN
  localparam logic [CW-1:0] STEP = CW'(2);
`else
  localparam logic [CW-1:0] STEP = CW'(1);
`endif
  localparam logic [CW-1:0] LAST_C = CW'(NUM_EDGES) - STEP;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t state, state_nx;

  logic [CW-1:0]           cnt;
  logic signed [WIDTH-1:0] rx_q, ry_q;
  logic signed [WIDTH-1:0] nx_q [NUM_EDGES];
  logic signed [WIDTH-1:0] ny_q [NUM_EDGES];
  logic [IDX_W-1:0]        idx_q;
  logic signed [DW-1:0]    min_q;

  logic                    last;
  logic signed [WIDTH-1:0] a_x, a_y;
  logic signed [DW-1:0]    dot_a;
  logic signed [DW-1:0]    pair_dot;
  logic [IDX_W-1:0]        pair_idx;
  logic                    take;

  function automatic logic signed [DW-1:0] dot(
    input logic signed [WIDTH-1:0] x,
    input logic signed [WIDTH-1:0] y,
    input logic signed [WIDTH-1:0] rx,
    input logic signed [WIDTH-1:0] ry
  );
    logic signed [DW-1:0] xe, ye, rxe, rye;
    xe  = x;
    ye  = y;
    rxe = rx;
    rye = ry;
    return xe*rxe + ye*rye;
  endfunction

  assign last = (cnt >= LAST_C);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state: start always (re)launches a scan
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (bus.start) state_nx = SCAN;
      SCAN: begin
        if (bus.start)  state_nx = SCAN;
        else if (last)  state_nx = DONE;
      end
      DONE: state_nx = bus.start ? SCAN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Fetch the edge(s) addressed by cnt from the latched copies
  always_comb begin
    a_x = '0;
    a_y = '0;
    for (int i = 0; i < NUM_EDGES; i++) begin
      if (CW'(i) == cnt) begin
        a_x = nx_q[i];
        a_y = ny_q[i];
      end
    end
  end

`ifdef INCIDENT_DUAL_LANE_EN
  logic [CW-1:0]           cnt_b;
  logic signed [WIDTH-1:0] b_x, b_y;
  logic                    b_ok;
  logic signed [DW-1:0]    dot_b;

  assign cnt_b = cnt + CW'(1);

  // Second lane reads edge cnt+1 when it exists
  always_comb begin
    b_x  = '0;
    b_y  = '0;
    b_ok = 1'b0;
    for (int i = 0; i < NUM_EDGES; i++) begin
      if (CW'(i) == cnt_b) begin
        b_x  = nx_q[i];
        b_y  = ny_q[i];
        b_ok = 1'b1;
      end
    end
  end

  assign dot_b = dot(b_x, b_y, rx_q, ry_q);
`endif

  assign dot_a = dot(a_x, a_y, rx_q, ry_q);

  // Best of this cycle's edges; lower index wins ties
  always_comb begin
    pair_dot = dot_a;
    pair_idx = cnt[IDX_W-1:0];
`ifdef INCIDENT_DUAL_LANE_EN
    if (b_ok && (dot_b < dot_a)) begin
      pair_dot = dot_b;
      pair_idx = cnt_b[IDX_W-1:0];
    end
`endif
    take = (cnt == '0) || (pair_dot < min_q);
  end

  // Latch inputs on start, otherwise fold scanned edges into the result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      rx_q  <= '0;
      ry_q  <= '0;
      idx_q <= '0;
      min_q <= '0;
      for (int i = 0; i < NUM_EDGES; i++) begin
        nx_q[i] <= '0;
        ny_q[i] <= '0;
      end
    end else if (bus.start) begin
      cnt  <= '0;
      rx_q <= bus.referenceNorm_x;
      ry_q <= bus.referenceNorm_y;
      for (int i = 0; i < NUM_EDGES; i++) begin
        nx_q[i] <= bus.norms_x[i*WIDTH +: WIDTH];
        ny_q[i] <= bus.norms_y[i*WIDTH +: WIDTH];
      end
    end else if (state == SCAN) begin
      cnt <= cnt + STEP;
      if (take) begin
        min_q <= pair_dot;
        idx_q <= pair_idx;
      end
    end
  end

  // Selected normal is a mux of the latched copies
  always_comb begin
    bus.incidentNorm_x = '0;
    bus.incidentNorm_y = '0;
    for (int i = 0; i < NUM_EDGES; i++) begin
      if (IDX_W'(i) == idx_q) begin
        bus.incidentNorm_x = nx_q[i];
        bus.incidentNorm_y = ny_q[i];
      end
    end
  end

  assign bus.busy          = (state == SCAN);
  assign bus.done_out      = (state == DONE);
  assign bus.incidentIndex = idx_q;
  assign bus.minDot        = min_q;
endmodule

// File: tb/tb_incident_edge_search.sv
// Directed bench for incident_edge_search.
// Covers default geometry and a 5-edge, 12-bit instance.
module tb_incident_edge_search;
  localparam int W   = 10;
  localparam int N   = 4;
  localparam int IW  = 2;
  localparam int W5  = 12;
  localparam int N5  = 5;
  localparam int IW5 = 3;
`ifdef INCIDENT_DUAL_LANE_EN
  localparam int LAT4 = 2;
  localparam int LAT5 = 3;
  localparam int RST_EDGES = 1;
`else
  localparam int LAT4 = 4;
  localparam int LAT5 = 5;
  localparam int RST_EDGES = 2;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  incident_edge_search_if #(.WIDTH(W), .NUM_EDGES(N), .IDX_W(IW)) bus ();
  incident_edge_search_if #(.WIDTH(W5), .NUM_EDGES(N5), .IDX_W(IW5)) bus5 ();

  incident_edge_search #(.WIDTH(W), .NUM_EDGES(N), .IDX_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  incident_edge_search #(.WIDTH(W5), .NUM_EDGES(N5), .IDX_W(IW5)) dut5 (
    .clk(clk), .rst_n(rst_n), .bus(bus5)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set4(input int rx, input int ry,
                      input int x0, input int y0, input int x1, input int y1,
                      input int x2, input int y2, input int x3, input int y3);
    bus.referenceNorm_x = W'(rx);
    bus.referenceNorm_y = W'(ry);
    bus.norms_x = {W'(x3), W'(x2), W'(x1), W'(x0)};
    bus.norms_y = {W'(y3), W'(y2), W'(y1), W'(y0)};
  endtask

  task automatic scramble();
    bus.referenceNorm_x  = W'($urandom);
    bus.referenceNorm_y  = W'($urandom);
    bus.norms_x          = {N*W{1'b0}} | {$urandom, $urandom};
    bus.norms_y          = {N*W{1'b0}} | {$urandom, $urandom};
    bus5.referenceNorm_x = W5'($urandom);
    bus5.referenceNorm_y = W5'($urandom);
    bus5.norms_x         = {N5*W5{1'b0}} | {$urandom, $urandom};
    bus5.norms_y         = {N5*W5{1'b0}} | {$urandom, $urandom};
  endtask

  task automatic go(input bit sel);
    @(negedge clk);
    if (sel) bus5.start = 1'b1;
    else     bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    bus5.start = 1'b0;
    scramble();
  endtask

  task automatic wait_done(input bit sel, output int lat);
    lat = 99;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (sel ? bus5.done_out : bus.done_out) begin
        lat = k;
        break;
      end
    end
  endtask

  int lat;
  int dn;

  initial begin
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus5.start = 1'b0;
    set4(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus5.referenceNorm_x = '0;
    bus5.referenceNorm_y = '0;
    bus5.norms_x = '0;
    bus5.norms_y = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done_out, 0);
    chk("rst_idx", bus.incidentIndex, 0);
    chk("rst_min", bus.minDot, 0);
    chk("rst_nx", bus.incidentNorm_x, 0);
    chk("rst_ny", bus.incidentNorm_y, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // box normals against (0,256)
    set4(0, 256, 0, 256, 256, 0, 0, -256, -256, 0);
    go(0);
    wait_done(0, lat);
    chk("box_lat", lat, LAT4);
    chk("box_busy", bus.busy, 0);
    chk("box_idx", bus.incidentIndex, 2);
    chk("box_nx", bus.incidentNorm_x, 0);
    chk("box_ny", bus.incidentNorm_y, -256);
    chk("box_min", bus.minDot, -65536);
    @(posedge clk);
    #1;
    chk("box_pulse", bus.done_out, 0);
    chk("box_hold", bus.minDot, -65536);

    // all products positive
    set4(256, 0, 256, 0, 200, 10, 100, 0, 255, 0);
    go(0);
    wait_done(0, lat);
    chk("pos_lat", lat, LAT4);
    chk("pos_idx", bus.incidentIndex, 2);
    chk("pos_min", bus.minDot, 25600);
    chk("pos_nx", bus.incidentNorm_x, 100);

    // tie keeps lowest index
    set4(256, 256, -256, 0, 0, -256, 256, 0, 0, 256);
    go(0);
    wait_done(0, lat);
    chk("tie_idx", bus.incidentIndex, 0);
    chk("tie_min", bus.minDot, -65536);
    chk("tie_nx", bus.incidentNorm_x, -256);

    // last edge wins
    set4(0, 256, 0, 10, 0, 5, 0, 3, 0, -1);
    go(0);
    wait_done(0, lat);
    chk("last_idx", bus.incidentIndex, 3);
    chk("last_min", bus.minDot, -256);
    chk("last_ny", bus.incidentNorm_y, -1);

    // restart two cycles after the first start
    set4(0, 256, 0, 256, 256, 0, 0, -256, -256, 0);
    go(0);
    @(posedge clk);
    #1;
    chk("rs_busy", bus.busy, 1);
    chk("rs_done", bus.done_out, 0);
    set4(256, 0, 256, 0, 200, 10, 100, 0, 255, 0);
    go(0);
    chk("rs_busy2", bus.busy, 1);
    wait_done(0, lat);
    chk("rs_lat", lat, LAT4);
    chk("rs_idx", bus.incidentIndex, 2);
    chk("rs_min", bus.minDot, 25600);

    // reset in the middle of a scan
    set4(0, 256, 0, 256, 256, 0, 0, -256, -256, 0);
    dn = 0;
    go(0);
    for (int i = 0; i < RST_EDGES; i++) begin
      @(posedge clk);
      #1;
      if (bus.done_out) dn++;
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mr_busy", bus.busy, 0);
    chk("mr_done", bus.done_out, 0);
    chk("mr_idx", bus.incidentIndex, 0);
    chk("mr_min", bus.minDot, 0);
    chk("mr_nx", bus.incidentNorm_x, 0);
    chk("mr_ny", bus.incidentNorm_y, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (bus.done_out) dn++;
    end
    chk("mr_nodone", dn, 0);
    set4(256, 256, -256, 0, 0, -256, 256, 0, 0, 256);
    go(0);
    wait_done(0, lat);
    chk("mr_lat", lat, LAT4);
    chk("mr_idx2", bus.incidentIndex, 0);
    chk("mr_min2", bus.minDot, -65536);

    // five edges, extreme values: positive maximum is never chosen
    bus5.referenceNorm_x = W5'(-2048);
    bus5.referenceNorm_y = W5'(-2048);
    bus5.norms_x = {W5'(-2048), {4*W5{1'b0}}};
    bus5.norms_y = {W5'(-2048), {4*W5{1'b0}}};
    go(1);
    wait_done(1, lat);
    chk("x5_lat", lat, LAT5);
    chk("x5_busy", bus5.busy, 0);
    chk("x5_idx", bus5.incidentIndex, 0);
    chk("x5_min", bus5.minDot, 0);
    chk("x5_nx", bus5.incidentNorm_x, 0);

    // five edges, odd tail wins
    bus5.referenceNorm_x = W5'(2047);
    bus5.referenceNorm_y = W5'(-2048);
    bus5.norms_x = {W5'(-2048), {4*W5{1'b0}}};
    bus5.norms_y = {W5'(2047), {4*W5{1'b0}}};
    go(1);
    wait_done(1, lat);
    chk("t5_lat", lat, LAT5);
    chk("t5_idx", bus5.incidentIndex, 4);
    chk("t5_min", bus5.minDot, -8384512);
    chk("t5_nx", bus5.incidentNorm_x, -2048);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
